redirect_ctrl: RTL and testbench

Redirect controller between the execute-stage branch unit, the trap/CSR logic and the fetch stage. Arbitrates concurrent PC-redirect requests (boot, trap, mret, branch/jump), holds the winning redirect until fetch accepts it, and drives pipeline flushes so wrong-path instructions never retire. All PC changes in the core go through this block.

---
 rtl/redirect_pkg.sv | 30 +++
 rtl/redirect_arb.sv | 48 ++++
 rtl/redirect_ctrl.sv | 139 +++++++++++++
 tb/tb_redirect_ctrl.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/redirect_pkg.sv
// Shared types for the PC-redirect controller: FSM states, redirect sources
// and the source priority ranking used for same-cycle arbitration and override.
package redirect_pkg;

    typedef enum logic [1:0] {
        ST_BOOT,
        ST_IDLE,
        ST_PEND
    } state_e;

    typedef enum logic [2:0] {
        SRC_NONE,
        SRC_BR,
        SRC_MRET,
        SRC_TRAP,
        SRC_BOOT
    } src_e;

    // A higher rank may displace a lower-ranked latched redirect.
    function automatic logic [2:0] src_rank(input src_e src);
        case (src)
            SRC_BOOT: return 3'd4;
            SRC_TRAP: return 3'd3;
            SRC_MRET: return 3'd2;
            SRC_BR:   return 3'd1;
            default:  return 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/redirect_arb.sv
// Fixed-priority redirect selector (trap > mret > branch). The latched source
// decides whether a new request may override a redirect already pending.
module redirect_arb
    import redirect_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            br_valid_i,
    input  logic            br_redirect_i,
    input  logic [XLEN-1:0] br_target_i,
    input  logic            trap_valid_i,
    input  logic [XLEN-1:0] trap_vector_i,
    input  logic            mret_valid_i,
    input  logic [XLEN-1:0] mepc_i,
    input  src_e            latched_src_i,
    output logic            win_valid_o,
    output src_e            win_src_o,
    output logic [XLEN-1:0] win_pc_o
);

    src_e            cand_src;
    logic [XLEN-1:0] cand_pc;

    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no path can infer a latch.
        cand_src = SRC_NONE;
        cand_pc  = '0;
        if (trap_valid_i) begin
            cand_src = SRC_TRAP;
            cand_pc  = trap_vector_i;
        end else if (mret_valid_i) begin
            cand_src = SRC_MRET;
            cand_pc  = mepc_i;
        end else if (br_valid_i && br_redirect_i) begin
            cand_src = SRC_BR;
            cand_pc  = br_target_i;
        end
    end

    // A trap always replaces a pending redirect, even another trap; anything
    // else must strictly outrank what is latched, so wrong-path branches lose.
    assign win_valid_o = (cand_src != SRC_NONE) &&
                         ((cand_src == SRC_TRAP) ||
                          (src_rank(cand_src) > src_rank(latched_src_i)));
    assign win_src_o   = cand_src;
    assign win_pc_o    = cand_pc;

endmodule

// File: rtl/redirect_ctrl.sv
// PC-redirect controller: arbitrates boot/trap/mret/branch redirects, holds the
// winner until fetch accepts it and drives pipeline flushes. Optional branch
// target alignment check is enabled by defining REDIRECT_MISALIGN_CHECK_EN.
module redirect_ctrl
    import redirect_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            br_valid,
    input  logic            br_redirect,
    input  logic [XLEN-1:0] br_target,
    input  logic            trap_valid,
    input  logic [XLEN-1:0] trap_vector,
    input  logic            mret_valid,
    input  logic [XLEN-1:0] mepc,
    input  logic            redirect_ready,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc,
    output logic            flush_if_id,
    output logic            flush_id_ex,
    output logic            misalign_valid,
    output logic [XLEN-1:0] misalign_addr
);

    state_e          state_q, state_d;
    src_e            src_q, src_d;
    logic [XLEN-1:0] pc_q, pc_d;

    logic            win_valid;
    src_e            win_src;
    logic [XLEN-1:0] win_pc;
    logic            br_misaligned;
    logic            event_accept;

    redirect_arb #(.XLEN(XLEN)) u_arb (
        .br_valid_i    (br_valid),
        .br_redirect_i (br_redirect),
        .br_target_i   (br_target),
        .trap_valid_i  (trap_valid),
        .trap_vector_i (trap_vector),
        .mret_valid_i  (mret_valid),
        .mepc_i        (mepc),
        .latched_src_i (src_q),
        .win_valid_o   (win_valid),
        .win_src_o     (win_src),
        .win_pc_o      (win_pc)
    );

`ifdef REDIRECT_MISALIGN_CHECK_EN
    assign br_misaligned = (win_src == SRC_BR) && win_pc[1];
`else
    assign br_misaligned = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        src_d        = src_q;
        pc_d         = pc_q;
        event_accept = 1'b0;
        case (state_q)
            ST_BOOT: begin
                if (redirect_ready) begin
                    state_d = ST_IDLE;
                    src_d   = SRC_NONE;
                end
            end
            ST_IDLE: begin
                if (win_valid) begin
                    event_accept = 1'b1;
                    if (!br_misaligned) begin
                        state_d = ST_PEND;
                        src_d   = win_src;
                        pc_d    = {win_pc[XLEN-1:1], 1'b0};
                    end
                end
            end
            ST_PEND: begin
                // An override in the handshake cycle keeps us pending on the new pc.
                if (win_valid) begin
                    src_d = win_src;
                    pc_d  = {win_pc[XLEN-1:1], 1'b0};
                end else if (redirect_ready) begin
                    state_d = ST_IDLE;
                    src_d   = SRC_NONE;
                end
            end
            default: begin
                state_d = ST_BOOT;
                src_d   = SRC_BOOT;
                pc_d    = RESET_PC;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state_q <= ST_BOOT;
            src_q   <= SRC_BOOT;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            pc_q    <= pc_d;
        end
    end

`ifdef REDIRECT_MISALIGN_CHECK_EN
    logic            mis_valid_q;
    logic [XLEN-1:0] mis_addr_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            mis_valid_q <= 1'b0;
            mis_addr_q  <= '0;
        end else begin
            mis_valid_q <= event_accept && br_misaligned;
            if (event_accept && br_misaligned) begin
                mis_addr_q <= win_pc;
            end
        end
    end

    assign misalign_valid = mis_valid_q;
    assign misalign_addr  = mis_addr_q;
`else
    assign misalign_valid = 1'b0;
    assign misalign_addr  = '0;
`endif

    assign redirect_valid = (state_q != ST_IDLE);
    assign redirect_pc    = pc_q;
    assign flush_if_id    = redirect_valid || event_accept;
    assign flush_id_ex    = redirect_valid || event_accept;

endmodule

// File: tb/tb_redirect_ctrl.sv
// Scoreboard bench for redirect_ctrl: directed stimulus pushes expected fetch
// PCs; a negedge monitor pops one per redirect handshake and compares.
module tb_redirect_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        br_valid;
    logic        br_redirect;
    logic [31:0] br_target;
    logic        trap_valid;
    logic [31:0] trap_vector;
    logic        mret_valid;
    logic [31:0] mepc;
    logic        redirect_ready;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        flush_if_id;
    logic        flush_id_ex;
    logic        misalign_valid;
    logic [31:0] misalign_addr;

    int          passed = 0;
    int          total  = 0;
    logic [31:0] exp_q[$];

    redirect_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .br_valid       (br_valid),
        .br_redirect    (br_redirect),
        .br_target      (br_target),
        .trap_valid     (trap_valid),
        .trap_vector    (trap_vector),
        .mret_valid     (mret_valid),
        .mepc           (mepc),
        .redirect_ready (redirect_ready),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .flush_if_id    (flush_if_id),
        .flush_id_ex    (flush_id_ex),
        .misalign_valid (misalign_valid),
        .misalign_addr  (misalign_addr)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Drive point: 1 time unit after the rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_events();
        br_valid    = 1'b0;
        br_redirect = 1'b0;
        trap_valid  = 1'b0;
        mret_valid  = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!rst && redirect_valid && redirect_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                $display("FAIL hs_unexpected: got pc %h expected no handshake", redirect_pc);
            end else begin
                check("hs_pc", redirect_pc, exp_q.pop_front());
            end
        end
    end

    initial begin
        rst = 1'b1; redirect_ready = 1'b0;
        br_target = '0; trap_vector = '0; mepc = '0;
        clear_events();

        // Reset / boot
        repeat (2) @(posedge clk);
        #2;
        check("rst_valid", {31'b0, redirect_valid}, 32'd1);
        check("rst_pc", redirect_pc, 32'h0000_0000);
        check("rst_flush_if_id", {31'b0, flush_if_id}, 32'd1);
        check("rst_flush_id_ex", {31'b0, flush_id_ex}, 32'd1);
        check("rst_misalign", {31'b0, misalign_valid}, 32'd0);
        check("rst_misalign_addr", misalign_addr, 32'd0);
        rst = 1'b0;
        exp_q.push_back(32'h0000_0000);
        redirect_ready = 1'b1;
        cyc();
        #1;
        check("idle_valid", {31'b0, redirect_valid}, 32'd0);
        check("idle_flush", {31'b0, flush_if_id}, 32'd0);

        // Simple branch redirect, one cycle PEND
        br_valid = 1'b1; br_redirect = 1'b1; br_target = 32'h0000_0104;
        #1;
        check("br_flush_n", {31'b0, flush_id_ex}, 32'd1);
        check("br_valid_n", {31'b0, redirect_valid}, 32'd0);
        exp_q.push_back(32'h0000_0104);
        cyc(); clear_events();
        #1;
        check("br_valid_n1", {31'b0, redirect_valid}, 32'd1);
        check("br_pc_n1", redirect_pc, 32'h0000_0104);
        cyc();
        #1;
        check("br_pend_one_cycle", {31'b0, redirect_valid}, 32'd0);

        // br_valid without br_redirect is not an event
        br_valid = 1'b1; br_target = 32'h0000_0800;
        #1;
        check("nored_flush", {31'b0, flush_if_id}, 32'd0);
        cyc(); clear_events();
        #1;
        check("nored_valid", {31'b0, redirect_valid}, 32'd0);

        // Trap beats same-cycle branch
        br_valid = 1'b1; br_redirect = 1'b1; br_target = 32'h0000_0200;
        trap_valid = 1'b1; trap_vector = 32'h8000_0000;
        exp_q.push_back(32'h8000_0000);
        cyc(); clear_events();
        #1;
        check("trap_prio_pc", redirect_pc, 32'h8000_0000);
        cyc();

        // Branch pending, mret overrides, later branch and mret ignored
        redirect_ready = 1'b0;
        br_valid = 1'b1; br_redirect = 1'b1; br_target = 32'h0000_0300;
        exp_q.push_back(32'h0000_0400);
        cyc(); clear_events();
        #1;
        check("pend_br_pc", redirect_pc, 32'h0000_0300);
        mret_valid = 1'b1; mepc = 32'h0000_0400;
        cyc(); clear_events();
        #1;
        check("mret_override_pc", redirect_pc, 32'h0000_0400);
        br_valid = 1'b1; br_redirect = 1'b1; br_target = 32'h0000_0500;
        cyc(); clear_events();
        #1;
        check("wrong_path_br_ignored", redirect_pc, 32'h0000_0400);
        mret_valid = 1'b1; mepc = 32'h0000_0600;
        cyc(); clear_events();
        #1;
        check("mret_over_mret_ignored", redirect_pc, 32'h0000_0400);
        check("pend_flush", {31'b0, flush_if_id}, 32'd1);
        redirect_ready = 1'b1;
        cyc();
        #1;
        check("mret_done_idle", {31'b0, redirect_valid}, 32'd0);

        // Trap override in the handshake cycle; bit 0 of latched pc cleared
        redirect_ready = 1'b0;
        br_valid = 1'b1; br_redirect = 1'b1; br_target = 32'h0000_0700;
        cyc(); clear_events();
        redirect_ready = 1'b1;
        trap_valid = 1'b1; trap_vector = 32'h0000_0901;
        exp_q.push_back(32'h0000_0700);
        exp_q.push_back(32'h0000_0900);
        cyc(); clear_events();
        #1;
        check("hs_override_valid", {31'b0, redirect_valid}, 32'd1);
        check("hs_override_pc", redirect_pc, 32'h0000_0900);
        cyc();
        #1;
        check("hs_override_idle", {31'b0, redirect_valid}, 32'd0);

        // Reset during PEND discards pending redirect; events ignored in BOOT
        redirect_ready = 1'b0;
        br_valid = 1'b1; br_redirect = 1'b1; br_target = 32'h0000_0300;
        cyc(); clear_events();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        trap_valid = 1'b1; trap_vector = 32'h0000_AAA0;
        #1;
        check("rst_pend_pc", redirect_pc, 32'h0000_0000);
        check("rst_pend_valid", {31'b0, redirect_valid}, 32'd1);
        cyc(); clear_events();
        #1;
        check("boot_trap_ignored", redirect_pc, 32'h0000_0000);
        exp_q.push_back(32'h0000_0000);
        redirect_ready = 1'b1;
        cyc();
        #1;
        check("boot_done_idle", {31'b0, redirect_valid}, 32'd0);

        // Branch target with bit 1 set
        br_valid = 1'b1; br_redirect = 1'b1; br_target = 32'h0000_0106;
        #1;
        check("mis_flush_n", {31'b0, flush_if_id}, 32'd1);
`ifdef REDIRECT_MISALIGN_CHECK_EN
        cyc(); clear_events();
        #1;
        check("mis_valid", {31'b0, misalign_valid}, 32'd1);
        check("mis_addr", misalign_addr, 32'h0000_0106);
        check("mis_no_redirect", {31'b0, redirect_valid}, 32'd0);
        cyc();
        #1;
        check("mis_pulse_end", {31'b0, misalign_valid}, 32'd0);
`else
        exp_q.push_back(32'h0000_0106);
        cyc(); clear_events();
        #1;
        check("c_redirect_pc", redirect_pc, 32'h0000_0106);
        check("c_no_misalign", {31'b0, misalign_valid}, 32'd0);
        cyc();
`endif

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) cyc();
        check("queue_drained", exp_q.size(), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
